// File: rtl/spad_quench_seq.sv
// spad_quench_seq: per-channel SPAD quench/holdoff/reset sequencer with synchronised edge detect
// Optional saturating event/miss counters enabled by defining SPAD_EVT_CNT_EN.
module spad_quench_seq #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EVT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       avl_in,
  input  logic [CNT_W-1:0]      quench_len,
  input  logic [CNT_W-1:0]      holdoff_len,
  input  logic [CNT_W-1:0]      reset_len,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       quench_en_n,
  output logic [N_CH-1:0]       rst_en,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       det_strobe,
  output logic [N_CH*EVT_W-1:0] evt_cnt,
  output logic [N_CH*EVT_W-1:0] miss_cnt
);
  typedef enum logic [1:0] {IDLE, QUENCH, HOLD, RESET} state_t;
  logic [SYNC_STAGES:0] rdy;
  logic [N_CH-1:0] edge_v, accept, drop;
  function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] x);
    return (x == '0) ? '0 : x - CNT_W'(1);
  endfunction
  // Edges are masked until the sync chain and prev reg hold real samples, so a line high at release is not an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) rdy <= '0;
    else     rdy <= {rdy[SYNC_STAGES-1:0], 1'b1};
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic prev, qn_r, re_r, qn_nxt, re_nxt;
    state_t state, nstate;
    logic [CNT_W-1:0] cnt, ncnt, hl, rl;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sync <= '0;
        prev <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], avl_in[c]};
        prev <= sync[SYNC_STAGES-1];
      end
    assign edge_v[c] = sync[SYNC_STAGES-1] & ~prev & rdy[SYNC_STAGES];
    assign accept[c] = (state == IDLE) & edge_v[c] & en[c];
    assign drop[c]   = (state != IDLE) & edge_v[c];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        hl    <= '0;
        rl    <= '0;
        qn_r  <= 1'b1;
        re_r  <= 1'b0;
      end else begin
        state <= nstate;
        cnt   <= ncnt;
        hl    <= accept[c] ? holdoff_len : hl;
        rl    <= accept[c] ? reset_len : rl;
        qn_r  <= qn_nxt;
        re_r  <= re_nxt;
      end
    // cnt holds remaining cycles minus one in the current phase
    always_comb begin
      nstate = state;
      ncnt   = cnt;
      case (state)
        IDLE: if (accept[c]) begin
          nstate = QUENCH;
          ncnt   = m1(quench_len);
        end
        QUENCH: if (cnt == '0) begin
          nstate = (hl == '0) ? RESET : HOLD;
          ncnt   = (hl == '0) ? m1(rl) : hl - CNT_W'(1);
        end else ncnt = cnt - CNT_W'(1);
        HOLD: if (cnt == '0) begin
          nstate = RESET;
          ncnt   = m1(rl);
        end else ncnt = cnt - CNT_W'(1);
        RESET: if (cnt == '0) nstate = IDLE;
               else ncnt = cnt - CNT_W'(1);
      endcase
    end
    always_comb begin
      qn_nxt = nstate != QUENCH;
      re_nxt = nstate == RESET;
    end
    assign quench_en_n[c] = qn_r;
    assign rst_en[c]      = re_r;
    assign busy[c]        = state != IDLE;
    assign det_strobe[c]  = accept[c];
`ifdef SPAD_EVT_CNT_EN
    logic [EVT_W-1:0] ec, mc;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        ec <= '0;
        mc <= '0;
      end else if (cnt_clr) begin
        ec <= '0;
        mc <= '0;
      end else begin
        ec <= (accept[c] && ~&ec) ? ec + EVT_W'(1) : ec;
        mc <= (drop[c] && ~&mc) ? mc + EVT_W'(1) : mc;
      end
    assign evt_cnt[c*EVT_W +: EVT_W]  = ec;
    assign miss_cnt[c*EVT_W +: EVT_W] = mc;
`else
    assign evt_cnt[c*EVT_W +: EVT_W]  = '0;
    assign miss_cnt[c*EVT_W +: EVT_W] = '0;
`endif
  end
`ifndef SPAD_EVT_CNT_EN
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, drop};
`endif
endmodule
